// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// The master is the sequencer; the slave is the datapath/memory side.
interface multicycle_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore sequencer for the multicycle MIPS core: fetch/decode/execute/memory/writeback
// over a shared memory port and ALU, with an optional memory ready handshake.
module multicycle_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  // Per-state control word; data-dependent terms are merged in at the outputs.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       jump;
    logic       branch;
    logic       rt_illegal;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

  // Returns {legal, alu_control}; unknown funct falls back to add.
  function automatic logic [3:0] funct_decode(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
      FN_SLT:  return {1'b1, ALU_SLT};
      FN_MUL:  return {1'b1, ALU_MUL};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy);
    logic [3:0] fd;
    fd = funct_decode(fn);
    case (s)
      S_FETCH:  return rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: return S_MEMADR;
          OP_RTYPE:     return S_RTEXEC;
          OP_BEQ:       return S_BRANCH;
          OP_ADDI:      return S_ADDIEXEC;
          OP_J:         return S_JUMP;
          default:      return S_FETCH;
        endcase
      end
      S_MEMADR:   return (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    return rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:    return rdy ? S_FETCH : S_MEMWR;
      S_RTEXEC:   return fd[3] ? S_ALUWB : S_FETCH;
      S_ADDIEXEC: return S_ALUWB;
      default:    return S_FETCH;
    endcase
  endfunction

  function automatic ctl_t ctl_for(input state_t s, input logic [5:0] fn, input logic addi);
    ctl_t       c;
    logic [3:0] fd;
    c  = '0;
    fd = funct_decode(fn);
    case (s)
      S_FETCH: begin
        c.mem_read    = 1'b1;
        c.fetch       = 1'b1;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RTEXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = fd[2:0];
        c.rt_illegal  = ~fd[3];
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = ~addi;
      end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
        c.branch      = 1'b1;
      end
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.jump   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;
  logic   addi_q;
  logic   rdy;

  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign nxt = next_state(state, bus.opcode, bus.funct, rdy);

  // Control word is registered for the state being entered, so it lines up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ctl_q  <= ctl_for(S_FETCH, 6'd0, 1'b0);
      addi_q <= 1'b0;
    end else begin
      state <= nxt;
      ctl_q <= ctl_for(nxt, bus.funct, addi_q);
      if (state == S_DECODE) addi_q <= (bus.opcode == OP_ADDI);
    end
  end

  // Enables are forced low while reset is held so an abandoned access cannot commit.
  assign bus.IorD       = ctl_q.iord;
  assign bus.MemRead    = rst_n & ctl_q.mem_read;
  assign bus.MemWrite   = rst_n & ctl_q.mem_write;
  assign bus.IRWrite    = rst_n & ctl_q.fetch & rdy;
  assign bus.RegDst     = ctl_q.reg_dst;
  assign bus.MemtoReg   = ctl_q.mem_to_reg;
  assign bus.RegWrite   = rst_n & ctl_q.reg_write;
  assign bus.ALUSrcA    = ctl_q.alu_src_a;
  assign bus.ALUSrcB    = ctl_q.alu_src_b;
  assign bus.ALUControl = ctl_q.alu_control;
  assign bus.PCSrc      = ctl_q.pc_src;
  assign bus.PCEn       = rst_n & ((ctl_q.fetch & rdy) | ctl_q.jump | (ctl_q.branch & bus.zero));
  assign bus.illegal_op = rst_n & (((state == S_DECODE) & ~op_legal(bus.opcode)) | ctl_q.rt_illegal);
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: each instruction is expanded into its
// phase list and every cycle's outputs are compared with a per-phase output table.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   stall_cnt;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] got_vec;
  assign got_vec = {bus.state_dbg, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                    bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                    bus.ALUControl, bus.PCSrc, bus.PCEn, bus.illegal_op};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit tb_op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

  function automatic bit tb_fn_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b101010, 6'b011100};
  endfunction

  // Expected outputs for one cycle spent in phase ph (phase number = state encoding).
  function automatic logic [20:0] exp_out(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input logic rdy, input bit addi);
    logic iord, mrd, mwr, irw, rdst, m2r, rw, sa, pe, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {iord, mrd, mwr, irw, rdst, m2r, rw, sa, pe, ill} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (ph)
      0:  begin mrd = 1; sb = 2'b01; ac = 3'b010; irw = rdy; pe = rdy; end
      1:  begin sb = 2'b11; ac = 3'b010; ill = !tb_op_legal(op); end
      2:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin
        sa = 1;
        case (fn)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b100;
          6'b101010: ac = 3'b110;
          6'b011100: ac = 3'b101;
          default:   begin ac = 3'b010; ill = 1; end
        endcase
      end
      7:  begin rw = 1; rdst = !addi; end
      8:  begin sa = 1; ac = 3'b100; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      10: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {4'(ph), iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, ac, ps, pe, ill};
  endfunction

  // zmode: 0/1 fixed zero flag, 2 random. rnd_rdy: random mem_ready instead of tied high.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input bit rnd_rdy);
    int seq[$];
    int waits;
    logic [20:0] e;
    seq = {0, 1};
    case (op)
      OP_LW:    seq = {seq, 2, 3, 4};
      OP_SW:    seq = {seq, 2, 5};
      OP_RTYPE: begin seq.push_back(6); if (tb_fn_legal(fn)) seq.push_back(7); end
      OP_BEQ:   seq.push_back(8);
      OP_ADDI:  seq = {seq, 9, 7};
      OP_J:     seq.push_back(10);
      default:  ;
    endcase
    @(posedge clk);
    #1;
    bus.opcode = op;
    bus.funct  = fn;
    foreach (seq[i]) begin
      waits = 0;
      do begin
        @(negedge clk);
        if (stall_cnt > 0) begin
          stall_cnt--;
          bus.mem_ready = 1'b0;
        end else if (rnd_rdy && waits < 6) bus.mem_ready = ($urandom_range(0, 2) != 0);
        else bus.mem_ready = 1'b1;
        bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        #1;
        e = exp_out(seq[i], op, fn, bus.zero, bus.mem_ready, op == OP_ADDI);
        check_eq($sformatf("op%b_fn%b_ph%0d", op, fn, seq[i]), 32'(got_vec), 32'(e));
        waits++;
      end while ((seq[i] inside {0, 3, 5}) && !bus.mem_ready);
    end
  endtask

  task automatic step(input logic rdy);
    @(negedge clk);
    bus.mem_ready = rdy;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] legal_fn [4];
    int k;
    legal_fn = '{6'b100000, 6'b100010, 6'b101010, 6'b011100};
    n_chk = 0; n_fail = 0; stall_cnt = 0;
    rst_n = 1'b0;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_state", 32'(bus.state_dbg), 32'd0);
    check_eq("reset_enables", 32'({bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                                   bus.PCEn, bus.illegal_op}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(OP_LW, 6'd0, 2, 1'b0);
    stall_cnt = 3;
    run_instr(OP_LW, 6'd0, 2, 1'b0);
    run_instr(OP_RTYPE, 6'b101010, 2, 1'b0);
    run_instr(OP_RTYPE, 6'b111111, 2, 1'b0);
    run_instr(OP_BEQ, 6'd0, 1, 1'b0);
    run_instr(OP_BEQ, 6'd0, 0, 1'b0);
    run_instr(6'b111111, 6'd0, 2, 1'b0);
    run_instr(OP_SW, 6'd0, 2, 1'b0);
    run_instr(OP_ADDI, 6'd0, 2, 1'b0);
    run_instr(OP_J, 6'd0, 2, 1'b0);

    // Reset while a store is waiting on memory.
    @(posedge clk);
    #1;
    bus.opcode = OP_SW;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check_eq("memwr_state", 32'(bus.state_dbg), 32'd5);
    check_eq("memwr_hold", 32'(bus.MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check_eq("rst_state", 32'(bus.state_dbg), 32'd0);
    check_eq("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_state", 32'(bus.state_dbg), 32'd0);
    check_eq("post_rst_fetch", 32'({bus.IorD, bus.MemRead}), 32'b01);
    run_instr(OP_LW, 6'd0, 2, 1'b1);

    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 7);
      fn = 6'($urandom_range(0, 63));
      case (k)
        0: op = OP_LW;
        1: op = OP_SW;
        2: begin op = OP_RTYPE; fn = legal_fn[$urandom_range(0, 3)]; end
        3: op = OP_RTYPE;
        4: op = OP_BEQ;
        5: op = OP_ADDI;
        6: op = OP_J;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (tb_op_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, fn, 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
